fir_channel_scheduler: RTL

Round-robin scheduler that shares one FIR filter core among NUM_CH deserialized sample channels. It accepts one LENGTH-bit word at a time from the channel-side deserializers, launches the shared core with a start pulse and waits for its done pulse. It then returns the filtered word, tagged with its source channel, over a valid/ready interface to the output serializer. It sits between the per-channel deserializer_fsm instances and the fir core.

---
 rtl/fir_channel_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one FIR core among NUM_CH sample channels.
// A channel is granted in IDLE, the core is launched in START, the result is
// awaited in WAIT (bounded by TIMEOUT) and handed to the serializer in OUT.
module fir_channel_scheduler #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned LENGTH  = 24,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [NUM_CH-1:0]        iv_req_valid,
    input  logic [NUM_CH*LENGTH-1:0] iv_req_data,
    output logic [NUM_CH-1:0]        ov_req_ready,
    output logic                     o_core_start,
    output logic [LENGTH-1:0]        ov_core_din,
    input  logic                     i_core_done,
    input  logic [LENGTH-1:0]        iv_core_dout,
    output logic [LENGTH-1:0]        ov_dout,
    output logic [CH_W-1:0]          ov_dout_ch,
    output logic                     o_dout_valid,
    input  logic                     i_ready,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [CH_W-1:0]     ptr_q,        ptr_d;
    logic [CH_W-1:0]     ch_q,         ch_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [LENGTH-1:0]   core_din_q,   core_din_d;
    logic                core_start_q, core_start_d;
    logic [LENGTH-1:0]   dout_q,       dout_d;
    logic [CH_W-1:0]     dout_ch_q,    dout_ch_d;
    logic                dout_valid_q, dout_valid_d;
    logic                busy_q,       busy_d;
    logic                timeout_q,    timeout_d;

    logic                found_c;
    logic [CH_W-1:0]     grant_ch_c;
    logic [CH_W-1:0]     scan_ch_c;

    // First requesting channel at or after ptr, wrapping at NUM_CH-1.
    always_comb begin
        found_c    = 1'b0;
        grant_ch_c = '0;
        scan_ch_c  = ptr_q;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (!found_c && iv_req_valid[scan_ch_c]) begin
                found_c    = 1'b1;
                grant_ch_c = scan_ch_c;
            end
            scan_ch_c = (scan_ch_c == CH_W'(NUM_CH - 1)) ? '0 : scan_ch_c + CH_W'(1);
        end
    end

    // Next-state, datapath and accept logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        ch_d         = ch_q;
        cnt_d        = cnt_q;
        core_din_d   = core_din_q;
        core_start_d = 1'b0;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        timeout_d    = 1'b0;
        ov_req_ready = '0;

        case (state_q)
            S_IDLE: begin
                // The accept is held off while reset is asserted so every output reads 0.
                if (i_en && found_c && i_rst_n) begin
                    ov_req_ready[grant_ch_c] = 1'b1;
                    core_din_d   = iv_req_data[32'(grant_ch_c) * LENGTH +: LENGTH];
                    ch_d         = grant_ch_c;
                    ptr_d        = (grant_ch_c == CH_W'(NUM_CH - 1)) ? '0
                                                                     : grant_ch_c + CH_W'(1);
                    core_start_d = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_core_done) begin
                    dout_d       = iv_core_dout;
                    dout_ch_d    = ch_q;
                    dout_valid_d = 1'b1;
                    state_d      = S_OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                    // Counter would reach TIMEOUT-1: drop the word.
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (i_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            ch_q         <= '0;
            cnt_q        <= '0;
            core_din_q   <= '0;
            core_start_q <= 1'b0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ch_q         <= ch_d;
            cnt_q        <= cnt_d;
            core_din_q   <= core_din_d;
            core_start_q <= core_start_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_core_start = core_start_q;
    assign ov_core_din  = core_din_q;
    assign ov_dout      = dout_q;
    assign ov_dout_ch   = dout_ch_q;
    assign o_dout_valid = dout_valid_q;
    assign o_busy       = busy_q;
    assign o_timeout    = timeout_q;

endmodule
